col_readout_seq: RTL and testbench

//  Frame readout sequencer for the pixel matrix. Consumes the re-timed pad signals from the front-end

---
 rtl/readout_pkg.sv | 46 ++++
 rtl/sync_edge_det.sv | 40 ++++
 rtl/col_readout_seq.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_col_readout_seq.sv | 399 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/readout_pkg.sv
// ----------------------------------------------------------------------------
// readout_pkg
//   Shared definitions for the column readout sequencer.
//   - 3-bit FSM state encoding (localparams plus the enum built on them)
//   - default geometry and timing parameters for a full-size matrix
//   - a small helper for sizing shared counters
// ----------------------------------------------------------------------------
package readout_pkg;

  // State encoding, kept as explicit constants so checkers and debug probes can
  // decode the raw 3-bit value without depending on the enum type.
  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_EXPOSE   = 3'd1;
  localparam logic [2:0] ST_SETTLE   = 3'd2;
  localparam logic [2:0] ST_REQ      = 3'd3;
  localparam logic [2:0] ST_WAIT_ACK = 3'd4;
  localparam logic [2:0] ST_PUSH     = 3'd5;
  localparam logic [2:0] ST_NEXT     = 3'd6;
  localparam logic [2:0] ST_DONE     = 3'd7;

  typedef enum logic [2:0] {
    IDLE     = ST_IDLE,
    EXPOSE   = ST_EXPOSE,
    SETTLE   = ST_SETTLE,
    REQ      = ST_REQ,
    WAIT_ACK = ST_WAIT_ACK,
    PUSH     = ST_PUSH,
    NEXT     = ST_NEXT,
    DONE     = ST_DONE
  } state_t;

  // Defaults for the full pixel matrix.
  localparam int N_COL_DEF       = 64;
  localparam int COL_W_DEF       = 6;
  localparam int N_ROW_DEF       = 64;
  localparam int ROW_W_DEF       = 7;
  localparam int SETTLE_CYC_DEF  = 8;
  localparam int ACK_TIMEOUT_DEF = 1024;

  // Larger of two integers; used to size the counter shared by SETTLE and
  // the handshake timeout.
  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// ----------------------------------------------------------------------------
// sync_edge_det
//   One-bit history register with combinational rise/fall decode. The input is
//   already re-timed to clk_40MHz upstream, so no extra synchroniser here.
//   Ports:
//     clk_40MHz  in   system clock
//     rst_n      in   asynchronous, active-low reset (history clears to 0)
//     d_i        in   level to watch
//     rise_o     out  ~prev & cur
//     fall_o     out  prev & ~cur
// ----------------------------------------------------------------------------
module sync_edge_det
  import readout_pkg::*;
(
  input  logic clk_40MHz,
  input  logic rst_n,
  input  logic d_i,
  output logic rise_o,
  output logic fall_o
);

  logic prev_q;
  logic prev_d;

  always_comb begin
    prev_d = d_i;
  end

  always_ff @(posedge clk_40MHz or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= prev_d;
    end
  end

  assign rise_o = ~prev_q & d_i;
  assign fall_o = prev_q & ~d_i;

endmodule

// File: rtl/col_readout_seq.sv
// ----------------------------------------------------------------------------
// col_readout_seq
//   Frame readout sequencer for the pixel matrix. Waits for the exposure
//   (shutter high) to end, lets the analog front-end settle, then walks the
//   columns: a request/acknowledge handshake per column followed by a burst of
//   N_ROW words, one word per rising edge of the external push clock.
//
//   Ports:
//     clk_40MHz          in   system clock
//     rst_n              in   asynchronous, active-low reset
//     shutter_i          in   re-timed shutter, high = exposure
//     mode_i             in   0 = full frame, 1 = single column (cfg_col_i);
//                             sampled at shutter fall
//     push_clk_i         in   re-timed external push clock (level)
//     shake_hands_col_i  in   column acknowledge (level)
//     cfg_col_i          in   column index for single-column mode
//     err_clr_i          in   1-cycle pulse clearing the sticky error flags
//     col_sel_o          out  current column index
//     col_req_o          out  column request
//     data_load_o        out  1-cycle pulse per pushed word
//     frame_done_o       out  1-cycle pulse at end of frame
//     busy_o             out  high from shutter fall until frame_done
//     ack_err_o          out  sticky: a column handshake timed out
//     overrun_o          out  sticky: shutter rose while busy
//
//   Column handshake: col_req_o rises one cycle after REQ and is held until
//   either shake_hands_col_i is seen high (the column is ready and the burst
//   starts) or ACK_TIMEOUT cycles pass (the column is skipped and ack_err_o is
//   set). The acknowledge is a level; it is only looked at while waiting, so
//   it may stay high into the burst without effect.
//
//   All outputs are registered: an action triggered by an edge visible on an
//   input shows up on the outputs one cycle later.
// ----------------------------------------------------------------------------
module col_readout_seq
  import readout_pkg::*;
#(
  parameter int N_COL       = N_COL_DEF,
  parameter int COL_W       = COL_W_DEF,
  parameter int N_ROW       = N_ROW_DEF,
  parameter int ROW_W       = ROW_W_DEF,
  parameter int SETTLE_CYC  = SETTLE_CYC_DEF,
  parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
  input  logic             clk_40MHz,
  input  logic             rst_n,
  input  logic             shutter_i,
  input  logic             mode_i,
  input  logic             push_clk_i,
  input  logic             shake_hands_col_i,
  input  logic [COL_W-1:0] cfg_col_i,
  input  logic             err_clr_i,
  output logic [COL_W-1:0] col_sel_o,
  output logic             col_req_o,
  output logic             data_load_o,
  output logic             frame_done_o,
  output logic             busy_o,
  output logic             ack_err_o,
  output logic             overrun_o
);

  // One counter serves both SETTLE and the handshake timeout, so it is sized
  // for the larger of the two.
  localparam int CNT_MAX = max2(SETTLE_CYC, ACK_TIMEOUT);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  // --------------------------------------------------------------------------
  // Edge detection on the re-timed pads
  // --------------------------------------------------------------------------
  logic shutter_rise;
  logic shutter_fall;
  logic push_rise;
  logic push_fall_unused;

  sync_edge_det u_shutter_edge (
    .clk_40MHz (clk_40MHz),
    .rst_n     (rst_n),
    .d_i       (shutter_i),
    .rise_o    (shutter_rise),
    .fall_o    (shutter_fall)
  );

  // Only rising push edges matter; the falling decode is left unused.
  sync_edge_det u_push_edge (
    .clk_40MHz (clk_40MHz),
    .rst_n     (rst_n),
    .d_i       (push_clk_i),
    .rise_o    (push_rise),
    .fall_o    (push_fall_unused)
  );

  // --------------------------------------------------------------------------
  // State and registered outputs
  // --------------------------------------------------------------------------
  state_t             state_q,      state_d;
  logic [CNT_W-1:0]   cnt_q,        cnt_d;
  logic [ROW_W-1:0]   row_cnt_q,    row_cnt_d;
  logic [COL_W-1:0]   col_sel_q,    col_sel_d;
  logic               mode_q,       mode_d;
  logic               col_req_q,    col_req_d;
  logic               data_load_q,  data_load_d;
  logic               frame_done_q, frame_done_d;
  logic               busy_q,       busy_d;
  logic               ack_err_q,    ack_err_d;
  logic               overrun_q,    overrun_d;

  // Error events raised by the FSM this cycle.
  logic               ack_timeout_evt;
  logic               overrun_evt;

  // --------------------------------------------------------------------------
  // Next-state and output decode
  // --------------------------------------------------------------------------
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    row_cnt_d       = row_cnt_q;
    col_sel_d       = col_sel_q;
    mode_d          = mode_q;
    col_req_d       = col_req_q;
    data_load_d     = 1'b0;
    frame_done_d    = 1'b0;
    busy_d          = busy_q;
    ack_timeout_evt = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Level sensitive: a shutter already high when a frame ends is
        // picked up here straight away.
        if (shutter_i) begin
          state_d = EXPOSE;
        end
      end

      EXPOSE: begin
        if (shutter_fall) begin
          mode_d = mode_i;
          if (mode_i) begin
            // Out-of-range single-column requests are pinned to the last
            // column rather than wrapping.
            if (32'(cfg_col_i) >= 32'(N_COL)) begin
              col_sel_d = COL_W'(N_COL - 1);
            end else begin
              col_sel_d = cfg_col_i;
            end
          end else begin
            col_sel_d = '0;
          end
          busy_d  = 1'b1;
          cnt_d   = '0;
          state_d = SETTLE;
        end
      end

      SETTLE: begin
        if (cnt_q == CNT_W'(SETTLE_CYC - 1)) begin
          cnt_d   = '0;
          state_d = REQ;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      REQ: begin
        col_req_d = 1'b1;
        cnt_d     = '0;
        state_d   = WAIT_ACK;
      end

      WAIT_ACK: begin
        if (shake_hands_col_i) begin
          col_req_d = 1'b0;
          row_cnt_d = '0;
          state_d   = PUSH;
        end else if (cnt_q == CNT_W'(ACK_TIMEOUT - 1)) begin
          // col_req_o has been high for ACK_TIMEOUT cycles: give up on
          // this column.
          col_req_d       = 1'b0;
          ack_timeout_evt = 1'b1;
          cnt_d           = '0;
          state_d         = NEXT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      PUSH: begin
        // The history register keeps running in every state, so a push
        // clock that is already high on entry shows no rise until it has
        // been low for at least one cycle.
        if (push_rise) begin
          data_load_d = 1'b1;
          row_cnt_d   = row_cnt_q + 1'b1;
          if (row_cnt_q == ROW_W'(N_ROW - 1)) begin
            state_d = NEXT;
          end
        end
      end

      NEXT: begin
        if (mode_q || (col_sel_q == COL_W'(N_COL - 1))) begin
          state_d = DONE;
        end else begin
          col_sel_d = col_sel_q + 1'b1;
          state_d   = REQ;
        end
      end

      DONE: begin
        frame_done_d = 1'b1;
        busy_d       = 1'b0;
        state_d      = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Sticky error flags: a new event in the same cycle as a clear wins.
  // --------------------------------------------------------------------------
  assign overrun_evt = shutter_rise & busy_q;

  always_comb begin
    ack_err_d = ack_err_q;
    if (ack_timeout_evt) begin
      ack_err_d = 1'b1;
    end else if (err_clr_i) begin
      ack_err_d = 1'b0;
    end

    overrun_d = overrun_q;
    if (overrun_evt) begin
      overrun_d = 1'b1;
    end else if (err_clr_i) begin
      overrun_d = 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_40MHz or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      row_cnt_q    <= '0;
      col_sel_q    <= '0;
      mode_q       <= 1'b0;
      col_req_q    <= 1'b0;
      data_load_q  <= 1'b0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
      ack_err_q    <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      row_cnt_q    <= row_cnt_d;
      col_sel_q    <= col_sel_d;
      mode_q       <= mode_d;
      col_req_q    <= col_req_d;
      data_load_q  <= data_load_d;
      frame_done_q <= frame_done_d;
      busy_q       <= busy_d;
      ack_err_q    <= ack_err_d;
      overrun_q    <= overrun_d;
    end
  end

  assign col_sel_o    = col_sel_q;
  assign col_req_o    = col_req_q;
  assign data_load_o  = data_load_q;
  assign frame_done_o = frame_done_q;
  assign busy_o       = busy_q;
  assign ack_err_o    = ack_err_q;
  assign overrun_o    = overrun_q;

endmodule

// File: tb/tb_col_readout_seq.sv
// ----------------------------------------------------------------------------
// tb_col_readout_seq
//   Directed bench for col_readout_seq with a small geometry
//   (N_COL=4, N_ROW=3, SETTLE_CYC=4, ACK_TIMEOUT=16).
// ----------------------------------------------------------------------------
module tb_col_readout_seq;

  localparam int N_COL       = 4;
  localparam int COL_W       = 3;
  localparam int N_ROW       = 3;
  localparam int ROW_W       = 3;
  localparam int SETTLE_CYC  = 4;
  localparam int ACK_TIMEOUT = 16;

  // --------------------------------------------------------------------------
  // DUT signals
  // --------------------------------------------------------------------------
  logic             clk_40MHz = 1'b0;
  logic             rst_n = 1'b0;
  logic             shutter_i = 1'b0;
  logic             mode_i = 1'b0;
  logic             push_clk_i = 1'b0;
  logic             shake_hands_col_i = 1'b0;
  logic [COL_W-1:0] cfg_col_i = '0;
  logic             err_clr_i = 1'b0;
  logic [COL_W-1:0] col_sel_o;
  logic             col_req_o;
  logic             data_load_o;
  logic             frame_done_o;
  logic             busy_o;
  logic             ack_err_o;
  logic             overrun_o;

  col_readout_seq #(
    .N_COL       (N_COL),
    .COL_W       (COL_W),
    .N_ROW       (N_ROW),
    .ROW_W       (ROW_W),
    .SETTLE_CYC  (SETTLE_CYC),
    .ACK_TIMEOUT (ACK_TIMEOUT)
  ) dut (
    .clk_40MHz         (clk_40MHz),
    .rst_n             (rst_n),
    .shutter_i         (shutter_i),
    .mode_i            (mode_i),
    .push_clk_i        (push_clk_i),
    .shake_hands_col_i (shake_hands_col_i),
    .cfg_col_i         (cfg_col_i),
    .err_clr_i         (err_clr_i),
    .col_sel_o         (col_sel_o),
    .col_req_o         (col_req_o),
    .data_load_o       (data_load_o),
    .frame_done_o      (frame_done_o),
    .busy_o            (busy_o),
    .ack_err_o         (ack_err_o),
    .overrun_o         (overrun_o)
  );

  // --------------------------------------------------------------------------
  // Clock
  // --------------------------------------------------------------------------
  initial begin
    forever #5 clk_40MHz = ~clk_40MHz;
  end

  // --------------------------------------------------------------------------
  // Bench controls (written only by the main sequence)
  // --------------------------------------------------------------------------
  logic             ack_en   = 1'b0;
  logic             skip_en  = 1'b0;
  logic [COL_W-1:0] skip_sel = '0;
  logic             push_en  = 1'b0;
  logic             push_man = 1'b0;

  // Column responder: acknowledge two cycles after a request is seen, drop
  // the acknowledge once the request goes away.
  initial begin : ack_responder
    int ack_wait;
    ack_wait = 0;
    forever begin
      @(negedge clk_40MHz);
      if (col_req_o && ack_en && !(skip_en && (col_sel_o == skip_sel))) begin
        ack_wait = ack_wait + 1;
        if (ack_wait >= 2) shake_hands_col_i = 1'b1;
      end else begin
        ack_wait = 0;
        shake_hands_col_i = 1'b0;
      end
    end
  end

  // Push clock: free-running period of 8 cycles, or a manual level.
  initial begin : push_gen
    int pcnt;
    pcnt = 0;
    forever begin
      @(negedge clk_40MHz);
      if (push_en) begin
        pcnt = pcnt + 1;
        if (pcnt == 4) begin
          push_clk_i = ~push_clk_i;
          pcnt = 0;
        end
      end else begin
        pcnt = 0;
        push_clk_i = push_man;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Monitor (owns the observation queues and counters)
  // --------------------------------------------------------------------------
  logic [COL_W-1:0] obs_load_q[$];
  logic [COL_W-1:0] obs_req_q[$];
  int               obs_len_q[$];
  int               done_cnt = 0;
  int               sel_bad  = 0;

  initial begin : monitor
    logic             req_prev;
    logic [COL_W-1:0] req_sel;
    int               req_run;
    req_prev = 1'b0;
    req_sel  = '0;
    req_run  = 0;
    forever begin
      @(negedge clk_40MHz);
      if (data_load_o) obs_load_q.push_back(col_sel_o);
      if (frame_done_o) done_cnt = done_cnt + 1;
      if (col_req_o) begin
        if (!req_prev) begin
          obs_req_q.push_back(col_sel_o);
          req_sel = col_sel_o;
          req_run = 0;
        end
        req_run = req_run + 1;
        if (col_sel_o != req_sel) sel_bad = sel_bad + 1;
      end else if (req_prev) begin
        obs_len_q.push_back(req_run);
      end
      req_prev = col_req_o;
    end
  end

  // --------------------------------------------------------------------------
  // Scoreboard
  // --------------------------------------------------------------------------
  logic [COL_W-1:0] exp_q[$];
  logic [COL_W-1:0] exp_req_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int lb, rb, qb, db, sb;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks = n_checks + 1;
    if (obs == exp) n_pass = n_pass + 1;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic frame_begin();
    lb = obs_load_q.size();
    rb = obs_req_q.size();
    qb = obs_len_q.size();
    db = done_cnt;
    sb = sel_bad;
    exp_q.delete();
    exp_req_q.delete();
  endtask

  // Expected loads/requests for a list of columns, each read out fully.
  task automatic expect_col(input int c);
    exp_req_q.push_back(COL_W'(c));
    for (int r = 0; r < N_ROW; r++) exp_q.push_back(COL_W'(c));
  endtask

  task automatic check_frame(input string pfx);
    int n_obs;
    n_obs = obs_load_q.size() - lb;
    check({pfx, "_n_loads"}, n_obs, exp_q.size());
    for (int i = 0; i < exp_q.size() && i < n_obs; i++)
      check({pfx, "_load_col"}, int'(obs_load_q[lb + i]), int'(exp_q[i]));
    n_obs = obs_req_q.size() - rb;
    check({pfx, "_n_reqs"}, n_obs, exp_req_q.size());
    for (int i = 0; i < exp_req_q.size() && i < n_obs; i++)
      check({pfx, "_req_col"}, int'(obs_req_q[rb + i]), int'(exp_req_q[i]));
  endtask

  // --------------------------------------------------------------------------
  // Driver tasks
  // --------------------------------------------------------------------------
  task automatic shutter_pulse(input int len);
    @(posedge clk_40MHz); #1;
    shutter_i = 1'b1;
    repeat (len) @(posedge clk_40MHz);
    #1;
    shutter_i = 1'b0;
  endtask

  task automatic run_frame(input logic m, input int cfg);
    mode_i    = m;
    cfg_col_i = COL_W'(cfg);
    shutter_pulse(10);
  endtask

  task automatic err_clear();
    @(posedge clk_40MHz); #1;
    err_clr_i = 1'b1;
    @(posedge clk_40MHz); #1;
    err_clr_i = 1'b0;
  endtask

  task automatic wait_done(input string pfx);
    int i;
    i = 0;
    while (done_cnt == db && i < 2000) begin
      @(negedge clk_40MHz);
      i = i + 1;
    end
    check({pfx, "_frame_done"}, done_cnt - db, 1);
    check({pfx, "_busy_end"}, int'(busy_o), 0);
  endtask

  task automatic wait_loads(input int n, input string pfx);
    int i;
    i = 0;
    while ((obs_load_q.size() - lb) < n && i < 2000) begin
      @(negedge clk_40MHz);
      i = i + 1;
    end
    check({pfx, "_load_wait"}, int'((obs_load_q.size() - lb) >= n), 1);
  endtask

  function automatic int all_outs();
    return int'({col_sel_o, col_req_o, data_load_o, frame_done_o,
                 busy_o, ack_err_o, overrun_o});
  endfunction

  // --------------------------------------------------------------------------
  // Main sequence
  // --------------------------------------------------------------------------
  initial begin : main
    int i;

    // Reset
    rst_n = 1'b0;
    repeat (3) @(negedge clk_40MHz);
    check("rst_col_sel",    int'(col_sel_o), 0);
    check("rst_col_req",    int'(col_req_o), 0);
    check("rst_data_load",  int'(data_load_o), 0);
    check("rst_frame_done", int'(frame_done_o), 0);
    check("rst_busy",       int'(busy_o), 0);
    check("rst_ack_err",    int'(ack_err_o), 0);
    check("rst_overrun",    int'(overrun_o), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk_40MHz);

    ack_en  = 1'b1;
    push_en = 1'b1;

    // 1. Full frame, all columns acknowledged.
    frame_begin();
    for (int c = 0; c < N_COL; c++) expect_col(c);
    run_frame(1'b0, 0);
    repeat (2) @(negedge clk_40MHz);
    check("t1_busy_after_fall", int'(busy_o), 1);
    wait_done("t1");
    check_frame("t1");
    repeat (5) @(negedge clk_40MHz);
    check("t1_done_once", done_cnt - db, 1);
    check("t1_sel_stable", sel_bad - sb, 0);

    // 2. Single column 2.
    frame_begin();
    expect_col(2);
    run_frame(1'b1, 2);
    wait_done("t2");
    check_frame("t2");
    check("t2_sel_stable", sel_bad - sb, 0);

    // 2b. Single column out of range is pinned to the last column.
    frame_begin();
    expect_col(N_COL - 1);
    run_frame(1'b1, 6);
    wait_done("t2b");
    check_frame("t2b");

    // 3. Column 1 never acknowledged.
    skip_en  = 1'b1;
    skip_sel = COL_W'(1);
    frame_begin();
    exp_req_q.push_back(COL_W'(0));
    for (int r = 0; r < N_ROW; r++) exp_q.push_back(COL_W'(0));
    exp_req_q.push_back(COL_W'(1));
    expect_col(2);
    expect_col(3);
    run_frame(1'b0, 0);
    wait_done("t3");
    check_frame("t3");
    check("t3_len_acked",   (obs_len_q.size() > qb)     ? obs_len_q[qb]     : -1, 2);
    check("t3_len_timeout", (obs_len_q.size() > qb + 1) ? obs_len_q[qb + 1] : -1, ACK_TIMEOUT);
    check("t3_ack_err_set", int'(ack_err_o), 1);
    err_clear();
    @(negedge clk_40MHz);
    check("t3_ack_err_clr", int'(ack_err_o), 0);
    skip_en = 1'b0;

    // 4. Shutter rises during the burst of column 0.
    frame_begin();
    for (int c = 0; c < N_COL; c++) expect_col(c);
    run_frame(1'b0, 0);
    wait_loads(1, "t4");
    @(posedge clk_40MHz); #1;
    shutter_i = 1'b1;
    repeat (3) @(posedge clk_40MHz);
    #1;
    shutter_i = 1'b0;
    @(negedge clk_40MHz);
    check("t4_overrun_set", int'(overrun_o), 1);
    wait_done("t4");
    check_frame("t4");

    // 4b. Clear coincident with a second overrun: the set wins.
    frame_begin();
    for (int c = 0; c < N_COL; c++) expect_col(c);
    run_frame(1'b0, 0);
    wait_loads(1, "t4b");
    @(posedge clk_40MHz); #1;
    shutter_i = 1'b1;
    err_clr_i = 1'b1;
    @(posedge clk_40MHz); #1;
    err_clr_i = 1'b0;
    @(negedge clk_40MHz);
    check("t4b_overrun_held", int'(overrun_o), 1);
    repeat (2) @(posedge clk_40MHz);
    #1;
    shutter_i = 1'b0;
    wait_done("t4b");
    check_frame("t4b");
    err_clear();
    @(negedge clk_40MHz);
    check("t4b_overrun_clr", int'(overrun_o), 0);

    // 5. Push clock already high when the burst starts.
    push_man = 1'b1;
    push_en  = 1'b0;
    frame_begin();
    expect_col(0);
    run_frame(1'b1, 0);
    i = 0;
    while (!((obs_req_q.size() > rb) && !col_req_o) && i < 500) begin
      @(negedge clk_40MHz);
      i = i + 1;
    end
    check("t5_push_entered", int'((obs_req_q.size() > rb) && !col_req_o), 1);
    repeat (6) @(negedge clk_40MHz);
    check("t5_no_load_high", obs_load_q.size() - lb, 0);
    for (int k = 1; k <= N_ROW; k++) begin
      @(posedge clk_40MHz); #1;
      push_man = 1'b0;
      repeat (3) @(posedge clk_40MHz);
      #1;
      push_man = 1'b1;
      repeat (6) @(negedge clk_40MHz);
      check("t5_one_per_rise", obs_load_q.size() - lb, k);
    end
    wait_done("t5");
    check_frame("t5");
    push_man = 1'b0;
    push_en  = 1'b1;

    // 6. Reset in the middle of column 2's burst.
    frame_begin();
    run_frame(1'b0, 0);
    wait_loads(2 * N_ROW + 1, "t6");
    rst_n = 1'b0;
    #1;
    check("t6_rst_async", all_outs(), 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_40MHz);
      check("t6_rst_hold", all_outs(), 0);
    end
    rst_n = 1'b1;
    repeat (20) @(negedge clk_40MHz);
    check("t6_no_done", done_cnt - db, 0);
    check("t6_idle_busy", int'(busy_o), 0);

    frame_begin();
    for (int c = 0; c < N_COL; c++) expect_col(c);
    run_frame(1'b0, 0);
    wait_done("t6b");
    check_frame("t6b");

    repeat (5) @(negedge clk_40MHz);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
